// File: rtl/pkt_pkg.sv
// pkt_pkg: shared types and defaults for the packet deframer.
package pkt_pkg;
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, HOLD} state_t;
  localparam logic [7:0] BCAST_ID_DEF = 8'hFF;
  localparam int TIMEOUT_DEF = 1024;
endpackage

// File: rtl/pkt_timeout.sv
// pkt_timeout: idle-cycle counter that pulses expire on the TIMEOUT-th enabled idle cycle.
module pkt_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign expire = en && !clr && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || !en || expire) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/pkt_deframer.sv
// pkt_deframer: strips ID/checksum framing, delivers payload addressed to this vehicle,
// pulses kill on broadcast frames and flags checksum and inter-byte timeout errors.
module pkt_deframer
  import pkt_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 2,
  parameter logic [7:0] BCAST_ID      = BCAST_ID_DEF,
  parameter int         TIMEOUT       = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 veh_id,
  input  logic [7:0]                 rx_frame,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [8*PAYLOAD_BYTES-1:0] data,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       kill,
  output logic                       chk_err,
  output logic                       tmo_err
);
  localparam int DW = 8 * PAYLOAD_BYTES;
  localparam int IW = $clog2(PAYLOAD_BYTES + 1);
  state_t state, state_nxt;
  logic [7:0] id_r, veh_r, xor_r;
  logic [IW-1:0] idx;
  logic xfer, busy, last, sum_ok, is_mine, expire;
  assign rx_ready   = state != HOLD;
  assign data_valid = state == HOLD;
  assign xfer       = rx_valid && rx_ready;
  assign busy       = state == PAYLOAD || state == CHECK;
  assign last       = idx == IW'(PAYLOAD_BYTES - 1);
  assign sum_ok     = rx_frame == xor_r;
  assign is_mine    = id_r == veh_r && veh_r != BCAST_ID;
  pkt_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (xfer),
    .en     (busy),
    .expire (expire)
  );
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = xfer ? PAYLOAD : IDLE;
      PAYLOAD: state_nxt = xfer ? (last ? CHECK : PAYLOAD) : (expire ? IDLE : PAYLOAD);
      CHECK:   state_nxt = xfer ? ((sum_ok && is_mine) ? HOLD : IDLE) : (expire ? IDLE : CHECK);
      HOLD:    state_nxt = data_ready ? IDLE : HOLD;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      id_r    <= '0;
      veh_r   <= '0;
      xor_r   <= '0;
      idx     <= '0;
      data    <= '0;
      kill    <= 1'b0;
      chk_err <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      kill    <= state == CHECK && xfer && sum_ok && id_r == BCAST_ID;
      chk_err <= state == CHECK && xfer && !sum_ok;
      tmo_err <= busy && expire;
      if (state == IDLE) begin
        xor_r <= xfer ? rx_frame : 8'h00;
        idx   <= '0;
        if (xfer) begin
          id_r  <= rx_frame;
          veh_r <= veh_id;
        end
      end else if (xfer) begin
        xor_r <= xor_r ^ rx_frame;
        if (state == PAYLOAD) begin
          idx  <= last ? '0 : idx + 1'b1;
          data <= (data << 8) | DW'(rx_frame);
        end
      end
    end
endmodule

// File: tb/tb_pkt_deframer.sv
// tb_pkt_deframer: directed and randomized frame checks against a frame-level reference model.
module tb_pkt_deframer;
  import pkt_pkg::*;
  logic clk = 0, rst_n = 0, rx_valid = 0, data_ready = 1;
  logic rx_ready, data_valid, kill, chk_err, tmo_err;
  logic [7:0] veh_id = 8'h05, rx_frame = 8'h00;
  logic [15:0] data;
  int n_tests = 0, n_fail = 0;
  int n_kill = 0, n_chk = 0, n_tmo = 0, n_dv = 0;
  int e_kill = 0, e_chk = 0, e_tmo = 0;
  logic [15:0] got_q[$], exp_q[$];
  always #5 clk = ~clk;
  pkt_deframer #(.PAYLOAD_BYTES(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .veh_id(veh_id), .rx_frame(rx_frame), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .kill(kill), .chk_err(chk_err), .tmo_err(tmo_err)
  );
  always @(negedge clk)
    if (rst_n) begin
      n_kill += int'(kill);
      n_chk  += int'(chk_err);
      n_tmo  += int'(tmo_err);
      n_dv   += int'(data_valid);
      if (data_valid && data_ready) got_q.push_back(data);
    end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    logic ok;
    rx_valid = 1;
    rx_frame = b;
    do begin
      @(negedge clk);
      ok = rx_ready;
      step();
      n++;
    end while (!ok && n < 60);
    if (!ok) check("rx_ready_wait", 0, 1);
    rx_valid = 0;
  endtask
  task automatic send_frame(input logic [7:0] id, input logic [15:0] pl, input logic [7:0] cs,
                            input int gap);
    logic [7:0] b[4];
    b[0] = id; b[1] = pl[15:8]; b[2] = pl[7:0]; b[3] = cs;
    for (int i = 0; i < 4; i++) begin
      send_byte(b[i]);
      if (i < 3) repeat ($urandom_range(0, gap)) step();
    end
  endtask
  task automatic expect_frame(input logic [7:0] id, input logic [15:0] pl, input logic [7:0] cs);
    if ((id ^ pl[15:8] ^ pl[7:0]) != cs) e_chk++;
    else if (id == 8'hFF) e_kill++;
    else if (id == veh_id) exp_q.push_back(pl);
  endtask
  task automatic settle(input string tag);
    data_ready = 1;
    repeat (3) step();
    check({tag, "_kill"}, n_kill, e_kill);
    check({tag, "_chk"}, n_chk, e_chk);
    check({tag, "_tmo"}, n_tmo, e_tmo);
    check({tag, "_ndata"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask
  task automatic frame(input string tag, input logic [7:0] id, input logic [15:0] pl,
                       input logic [7:0] cs, input int gap);
    expect_frame(id, pl, cs);
    send_frame(id, pl, cs, gap);
    settle(tag);
  endtask
  initial begin
    int dv0, first;
    logic [7:0] id, cs;
    logic [15:0] pl;
    repeat (3) step();
    check("rst_rx_ready", rx_ready, 1);
    check("rst_data_valid", data_valid, 0);
    check("rst_pulses", {kill, chk_err, tmo_err}, 0);
    check("rst_data", data, 0);
    rst_n = 1;
    step();
    dv0 = n_dv;
    frame("good", 8'h05, 16'h1234, 8'h23, 0);
    check("good_dv_cycles", n_dv - dv0, 1);
    dv0 = n_dv;
    frame("bcast", 8'hFF, 16'h0000, 8'hFF, 0);
    check("bcast_no_dv", n_dv - dv0, 0);
    frame("badsum", 8'h05, 16'h1234, 8'h00, 0);
    frame("after_bad", 8'h05, 16'h1234, 8'h23, 0);
    frame("other", 8'h07, 16'hAABB, 8'h16, 0);
    check("other_idle", rx_ready, 1);
    data_ready = 0;
    expect_frame(8'h05, 16'hBEEF, 8'h05 ^ 8'hBE ^ 8'hEF);
    send_frame(8'h05, 16'hBEEF, 8'h05 ^ 8'hBE ^ 8'hEF, 0);
    for (int i = 0; i < 5; i++) begin
      check("hold_dv", data_valid, 1);
      check("hold_data", data, 16'hBEEF);
      check("hold_rx_ready", rx_ready, 0);
      step();
    end
    data_ready = 1;
    step();
    check("hold_release_dv", data_valid, 0);
    check("hold_release_rdy", rx_ready, 1);
    settle("hold");
    send_byte(8'h05);
    send_byte(8'h12);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (tmo_err && first == 0) first = i;
    end
    e_tmo++;
    check("tmo_cycle", first, 16);
    settle("tmo");
    send_byte(8'h05);
    send_byte(8'h12);
    rst_n = 0;
    step();
    check("midrst_pulses", {kill, chk_err, tmo_err, data_valid}, 0);
    check("midrst_rx_ready", rx_ready, 1);
    rst_n = 1;
    step();
    frame("after_rst", 8'h05, 16'h1234, 8'h23, 0);
    for (int f = 0; f < 150; f++) begin
      case ($urandom_range(0, 3))
        0: id = 8'h05;
        1: id = 8'hFF;
        2: id = 8'h07;
        default: id = 8'($urandom);
      endcase
      pl = 16'($urandom);
      cs = id ^ pl[15:8] ^ pl[7:0];
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 9) == 0) begin
        send_byte(id);
        for (int k = $urandom_range(0, 2); k > 0; k--) send_byte(8'($urandom));
        repeat (18) step();
        e_tmo++;
        settle("rnd_tmo");
      end else begin
        data_ready = $urandom_range(0, 1) == 1;
        expect_frame(id, pl, cs);
        send_frame(id, pl, cs, 6);
        repeat ($urandom_range(0, 4)) step();
        settle("rnd");
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
